// File: rtl/variable_unshift_stage.sv
// Receive-side variable right shifter: config packets set the shift amount, and shifted data packets go out through a 2-entry FIFO.
// Optional build macro VARSHIFT_ARITH_EN switches the data shift to an arithmetic shift that fills with the message MSB.
module variable_unshift_stage #(
  parameter int                    ADDR_SIZE    = 4,
  parameter int                    PAYLOAD_SIZE = 8,
  parameter logic [ADDR_SIZE-1:0]  CONFIG_ADDR  = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              recv_val,
  output logic                              recv_rdy,
  input  logic [ADDR_SIZE+PAYLOAD_SIZE:0]   recv_msg,
  output logic                              send_val,
  input  logic                              send_rdy,
  output logic [ADDR_SIZE+PAYLOAD_SIZE:0]   send_msg,
  output logic [4:0]                        cur_shamt
);

  localparam int W = ADDR_SIZE + PAYLOAD_SIZE + 1;

  logic [4:0]   r_shamt;
  logic [1:0]   r_count;
  logic [W-1:0] r_entry0;
  logic [W-1:0] r_entry1;

  logic         w_recv_fire;
  logic         w_send_fire;
  logic         w_is_cfg;
  logic         w_push;
  logic [W-1:0] w_shifted;

  assign recv_rdy    = reset && (r_count < 2'd2);
  assign send_val    = (r_count != 2'd0);
  assign send_msg    = r_entry0;
  assign cur_shamt   = r_shamt;

  assign w_recv_fire = recv_val && recv_rdy;
  assign w_send_fire = send_val && send_rdy;
  assign w_is_cfg    = recv_msg[W-1] && (recv_msg[W-2:PAYLOAD_SIZE] == CONFIG_ADDR);
  assign w_push      = w_recv_fire && !w_is_cfg;

`ifdef VARSHIFT_ARITH_EN
  assign w_shifted = $signed(recv_msg) >>> r_shamt;
`else
  assign w_shifted = recv_msg >> r_shamt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shamt <= '0;
    end else if (w_recv_fire && w_is_cfg) begin
      r_shamt <= recv_msg[4:0];
    end
  end

  // Entry 0 is always the head, so the output keeps its last value once the FIFO empties.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count  <= '0;
      r_entry0 <= '0;
      r_entry1 <= '0;
    end else begin
      case ({w_push, w_send_fire})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_entry0 <= w_shifted;
          end else begin
            r_entry1 <= w_shifted;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd2) begin
            r_entry0 <= r_entry1;
          end
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          r_entry0 <= w_shifted;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
